lm80c_pio: RTL



---
 rtl/lm80c_pio_pkg.sv | 25 ++
 rtl/lm80c_pio_port.sv | 164 ++++++++++++++++
 rtl/lm80c_pio.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lm80c_pio_pkg.sv
// Shared types and constants for the LM80C parallel I/O block.
package lm80c_pio_pkg;

    localparam int unsigned DATA_W = 8;

    // Low nibble of a control word selecting the mode or interrupt-enable form.
    localparam logic [3:0] CTRL_MODE = 4'hF;
    localparam logic [3:0] CTRL_IE   = 4'h7;

    typedef enum logic [1:0] {
        MODE_OUT = 2'b00,
        MODE_IN  = 2'b01,
        MODE_BIT = 2'b11
    } pio_mode_e;

    // Reserved encoding 2'b10 falls back to output mode.
    function automatic pio_mode_e decode_mode(input logic [1:0] code);
        case (code)
            2'b01:   return MODE_IN;
            2'b11:   return MODE_BIT;
            default: return MODE_OUT;
        endcase
    endfunction

endpackage

// File: rtl/lm80c_pio_port.sv
// One PIO port: mode/control registers, strobe synchroniser, handshake and
// interrupt pending flag. Bus events arrive already edge-qualified.
module lm80c_pio_port
    import lm80c_pio_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wr_data,
    input  logic              wr_ctrl,
    input  logic              rd_done,
    input  logic              ack_clr,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] pin,
    input  logic              strb_n,
    output logic [DATA_W-1:0] port_out,
    output logic [DATA_W-1:0] port_oe,
    output logic [DATA_W-1:0] rd_val,
    output logic [DATA_W-1:0] vector,
    output logic [DATA_W-1:0] status,
    output logic              rdy,
    output logic              irq
);

    pio_mode_e         mode_q, mode_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] vec_q, vec_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] oe_q, oe_d;
    logic [DATA_W-1:0] latch_q, latch_d;
    logic              ie_q, ie_d;
    logic              pend_q, pend_d;
    logic              full_q, full_d;
    logic              exp_q, exp_d;
    logic              rdy_q, rdy_d;
    logic [2:0]        sync_q, sync_d;
    logic              fall_c;

    // sync_q[1] is the synchronised strobe, sync_q[2] its previous value.
    assign fall_c = sync_q[2] & ~sync_q[1];

    always_comb begin
        mode_d  = mode_q;
        mask_d  = mask_q;
        vec_d   = vec_q;
        out_d   = out_q;
        oe_d    = oe_q;
        latch_d = latch_q;
        ie_d    = ie_q;
        pend_d  = pend_q;
        full_d  = full_q;
        exp_d   = exp_q;
        rdy_d   = rdy_q;
        sync_d  = {sync_q[1:0], strb_n};

        if (wr_ctrl) begin
            if (exp_q) begin
                mask_d = din;
                exp_d  = 1'b0;
            end else if (din[3:0] == CTRL_MODE) begin
                mode_d = decode_mode(din[7:6]);
                exp_d  = (din[7:6] == 2'b11);
            end else if (din[3:0] == CTRL_IE) begin
                ie_d   = din[7];
                pend_d = 1'b0;
            end else if (!din[0]) begin
                vec_d = {din[7:1], 1'b0};
            end
        end

        if (ack_clr) begin
            pend_d = 1'b0;
        end

        if (wr_data) begin
            out_d = din;
            if (mode_q == MODE_OUT) begin
                rdy_d = 1'b1;
            end
        end

        if (rd_done) begin
            full_d = 1'b0;
        end

        // Strobe events come last so they win over acks and CPU writes.
        case (mode_q)
            MODE_OUT: begin
                if (fall_c) begin
                    rdy_d = 1'b0;
                    if (ie_q) pend_d = 1'b1;
                end
            end
            MODE_IN: begin
                if (fall_c && !full_q) begin
                    latch_d = pin;
                    full_d  = 1'b1;
                    if (ie_q) pend_d = 1'b1;
                end
            end
            default: ;
        endcase

        case (mode_d)
            MODE_IN: begin
                oe_d  = '0;
                rdy_d = ~full_d;
            end
            MODE_BIT: begin
                oe_d  = ~mask_d;
                rdy_d = 1'b0;
            end
            default: oe_d = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_OUT;
            mask_q  <= '0;
            vec_q   <= '0;
            out_q   <= RESET_VAL;
            oe_q    <= '1;
            latch_q <= '0;
            ie_q    <= 1'b0;
            pend_q  <= 1'b0;
            full_q  <= 1'b0;
            exp_q   <= 1'b0;
            rdy_q   <= 1'b0;
            sync_q  <= 3'b111;
        end else if (ena) begin
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            vec_q   <= vec_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            latch_q <= latch_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
            full_q  <= full_d;
            exp_q   <= exp_d;
            rdy_q   <= rdy_d;
            sync_q  <= sync_d;
        end
    end

    always_comb begin
        case (mode_q)
            MODE_IN:  rd_val = latch_q;
            MODE_BIT: rd_val = (pin & mask_q) | (out_q & ~mask_q);
            default:  rd_val = out_q;
        endcase
    end

    assign port_out = out_q;
    assign port_oe  = oe_q;
    assign vector   = vec_q;
    assign rdy      = rdy_q;
    assign irq      = pend_q & ie_q;
    assign status   = {mode_q, ie_q, pend_q, full_q, exp_q, rdy_q, 1'b0};

endmodule

// File: rtl/lm80c_pio.sv
// LM80C parallel I/O block: bus decode, strobe edge qualification,
// interrupt priority and read/vector mux around NPORTS port slices.
module lm80c_pio
    import lm80c_pio_pkg::*;
#(
    parameter int unsigned         NPORTS    = 2,
    parameter logic [3:0]          BASE      = 4'h0,
    parameter logic [8*NPORTS-1:0] RESET_OUT = (8*NPORTS)'(16'h0100)
) (
    input  logic                sys_clock,
    input  logic                RESET,
    input  logic                clock_ena,
    input  logic [7:0]          A,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    input  logic                iorq_n,
    input  logic                m1_n,
    input  logic                rd_n,
    input  logic                wr_n,
    output logic                int_n,
    input  logic [8*NPORTS-1:0] port_in,
    output logic [8*NPORTS-1:0] port_out,
    output logic [8*NPORTS-1:0] port_oe,
    input  logic [NPORTS-1:0]   strb_n,
    output logic [NPORTS-1:0]   rdy
);

    localparam int unsigned OFF_W = 5;

    logic [3:0]        off;
    logic              sel_c, wr_now_c, rd_now_c, ack_now_c;
    logic              wr_act_c, rd_act_c, ack_act_c;
    logic              wr_q, wr_d, rd_q, rd_d, ack_q, ack_d;
    logic [NPORTS-1:0] rd_seen_q, rd_seen_d;
    logic [NPORTS-1:0] rd_done, irq, win_oh, ack_clr;
    logic              irq_any;
    logic [7:0]        ack_vec, rd_mux;
    logic [7:0]        data_a [NPORTS];
    logic [7:0]        stat_a [NPORTS];
    logic [7:0]        vec_a  [NPORTS];

    assign off       = A[3:0];
    assign sel_c     = ~iorq_n & m1_n & (A[7:4] == BASE);
    assign wr_now_c  = sel_c & ~wr_n;
    assign rd_now_c  = sel_c & ~rd_n;
    assign ack_now_c = ~m1_n & ~iorq_n;

    // Act only on the first enabled cycle of each bus strobe.
    assign wr_act_c  = clock_ena & wr_now_c  & ~wr_q;
    assign rd_act_c  = clock_ena & rd_now_c  & ~rd_q;
    assign ack_act_c = clock_ena & ack_now_c & ~ack_q;

    always_comb begin
        wr_d      = wr_now_c;
        rd_d      = rd_now_c;
        ack_d     = ack_now_c;
        rd_seen_d = rd_seen_q;
        if (!rd_now_c) begin
            rd_seen_d = '0;
        end
        for (int p = 0; p < int'(NPORTS); p++) begin
            if (rd_act_c && ({1'b0, off} == OFF_W'(p))) begin
                rd_seen_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            ack_q     <= 1'b0;
            rd_seen_q <= '0;
        end else if (clock_ena) begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            ack_q     <= ack_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    // A data read releases the input latch when its strobe goes away.
    assign rd_done = {NPORTS{clock_ena & ~rd_now_c}} & rd_seen_q;

    for (genvar g = 0; g < int'(NPORTS); g++) begin : g_port
        lm80c_pio_port #(
            .RESET_VAL (RESET_OUT[8*g +: 8])
        ) u_port (
            .clk      (sys_clock),
            .rst      (RESET),
            .ena      (clock_ena),
            .wr_data  (wr_act_c && ({1'b0, off} == OFF_W'(g))),
            .wr_ctrl  (wr_act_c && ({1'b0, off} == OFF_W'(NPORTS + g))),
            .rd_done  (rd_done[g]),
            .ack_clr  (ack_clr[g]),
            .din      (din),
            .pin      (port_in[8*g +: 8]),
            .strb_n   (strb_n[g]),
            .port_out (port_out[8*g +: 8]),
            .port_oe  (port_oe[8*g +: 8]),
            .rd_val   (data_a[g]),
            .vector   (vec_a[g]),
            .status   (stat_a[g]),
            .rdy      (rdy[g]),
            .irq      (irq[g])
        );
    end

    // Lowest-numbered requesting port wins the acknowledge.
    always_comb begin
        irq_any = 1'b0;
        win_oh  = '0;
        ack_vec = 8'h00;
        for (int p = 0; p < int'(NPORTS); p++) begin
            if (irq[p] && !irq_any) begin
                irq_any   = 1'b1;
                win_oh[p] = 1'b1;
                ack_vec   = vec_a[p];
            end
        end
    end

    assign ack_clr = win_oh & {NPORTS{ack_act_c}};
    assign int_n   = ~|irq;

    always_comb begin
        rd_mux = 8'hFF;
        for (int p = 0; p < int'(NPORTS); p++) begin
            if ({1'b0, off} == OFF_W'(p)) begin
                rd_mux = data_a[p];
            end
            if ({1'b0, off} == OFF_W'(NPORTS + p)) begin
                rd_mux = stat_a[p];
            end
        end
    end

    always_comb begin
        dout = 8'h00;
        if (ack_now_c) begin
            dout = irq_any ? ack_vec : 8'h00;
        end else if (rd_now_c) begin
            dout = rd_mux;
        end
    end

endmodule
